// File: rtl/expr_alu_sequencer.sv
// Sequencer that evaluates t0 +/- t1 +/- ... on an external add/sub ALU.
// Optional `SATURATE_EN: clamp the accumulator on ALU signed overflow instead of wrapping.
module expr_alu_sequencer #(
  parameter int WIDTH     = 16,
  parameter int MAX_TERMS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_op,
  input  logic             in_last,
  output logic             alu_h,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             trunc_err,
  output logic [7:0]       term_count
);

  typedef enum logic [2:0] {
    IDLE,
    FIRST,
    NEXT,
    EXEC,
    DONE
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] b_reg;
  logic             h_reg;
  logic             last_reg;
  logic [WIDTH-1:0] acc_nx;
  logic             hs;
  logic             at_max;

  assign hs     = in_valid & in_ready;
  assign at_max = (term_count == 8'(MAX_TERMS));

  assign alu_a  = acc;
  assign alu_b  = b_reg;
  assign alu_h  = h_reg;
  // result tracks acc directly, so it holds the previous value until t0 overwrites acc.
  assign result = acc;

`ifdef SATURATE_EN
  always_comb begin
    acc_nx = alu_result;
    if (alu_overflow) begin
      acc_nx = acc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  always_comb begin
    acc_nx = alu_result;
  end
`endif

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    in_ready = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = FIRST;
      end
      FIRST: begin
        in_ready = 1'b1;
        if (hs) state_nx = in_last ? DONE : NEXT;
      end
      NEXT: begin
        in_ready = 1'b1;
        if (hs) state_nx = EXEC;
      end
      EXEC: begin
        if (last_reg || at_max) state_nx = DONE;
        else                    state_nx = NEXT;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      b_reg      <= '0;
      h_reg      <= 1'b0;
      last_reg   <= 1'b0;
      term_count <= '0;
      overflow   <= 1'b0;
      trunc_err  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            overflow   <= 1'b0;
            trunc_err  <= 1'b0;
            term_count <= '0;
          end
        end
        FIRST: begin
          if (hs) begin
            acc        <= in_data;
            term_count <= 8'd1;
          end
        end
        NEXT: begin
          if (hs) begin
            b_reg      <= in_data;
            h_reg      <= in_op;
            last_reg   <= in_last;
            term_count <= term_count + 8'd1;
          end
        end
        EXEC: begin
          acc      <= acc_nx;
          overflow <= overflow | alu_overflow;
          if (!last_reg && at_max) trunc_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_expr_alu_sequencer.sv
// Directed self-checking bench for expr_alu_sequencer with a behavioural add/sub ALU attached.
module tb_expr_alu_sequencer;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_op;
  logic             in_last;
  logic             alu_h;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_overflow;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             trunc_err;
  logic [7:0]       term_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Reference ALU: signed add/sub with two's-complement overflow detection.
  assign alu_result   = alu_h ? (alu_a - alu_b) : (alu_a + alu_b);
  assign alu_overflow = alu_h ?
    ((alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_result[WIDTH-1] != alu_a[WIDTH-1])) :
    ((alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_result[WIDTH-1] != alu_a[WIDTH-1]));

  expr_alu_sequencer #(.WIDTH(WIDTH), .MAX_TERMS(3)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_op(in_op), .in_last(in_last),
    .alu_h(alu_h), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .busy(busy), .done(done), .result(result), .overflow(overflow),
    .trunc_err(trunc_err), .term_count(term_count)
  );

  task automatic start_expr();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns one time unit after the accepting clock edge.
  task automatic send_term(input logic [WIDTH-1:0] d, input logic op, input logic last);
    bit ok = 0;
    in_valid = 1'b1; in_data = d; in_op = op; in_last = last;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1;
      end
    end
    in_valid = 1'b0; in_last = 1'b0; in_op = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_term_timeout: in_ready=%b required 1 within 20 cycles", in_ready);
    end
  endtask

  // Counts falling edges until done is seen; returns sampling at the done cycle.
  task automatic wait_done(input int exp_cyc, input string name);
    int cyc = 0;
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1;
    end
    checks++;
    if (!seen || cyc != exp_cyc) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles (seen=%0b) required %0d", name, cyc, seen, exp_cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_op = 1'b0; in_last = 1'b0;
    #3;
    checks++;
    if ({busy, in_ready, done, overflow, trunc_err, alu_h} !== 6'b0 ||
        result !== '0 || term_count !== 8'd0 || alu_a !== '0 || alu_b !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b rdy=%b done=%b ovf=%b tr=%b h=%b res=%h cnt=%0d a=%h b=%h required all 0",
               busy, in_ready, done, overflow, trunc_err, alu_h, result, term_count, alu_a, alu_b);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    start_expr();
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_first: busy=%b in_ready=%b required 1 1", busy, in_ready);
    end
    send_term(16'd5, 1'b0, 1'b0);
    send_term(16'd3, 1'b0, 1'b0);
    send_term(16'd2, 1'b1, 1'b1);
    wait_done(2, "basic");
    checks++;
    if (result !== 16'd6 || overflow !== 1'b0 || term_count !== 8'd3 || trunc_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_result: res=%h ovf=%b cnt=%0d tr=%b busy=%b required 0006 0 3 0 1",
               result, overflow, term_count, trunc_err, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 16'd6) begin
      errors++; $display("FAIL basic_after: done=%b busy=%b res=%h required 0 0 0006", done, busy, result);
    end
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] exp;
`ifdef SATURATE_EN
    exp = 16'h7FFF;
`else
    exp = 16'h8000;
`endif
    start_expr();
    checks++;
    if (result !== 16'd6) begin
      errors++; $display("FAIL result_hold_after_start: res=%h required 0006", result);
    end
    send_term(16'h7FFF, 1'b1, 1'b0);
    send_term(16'h0001, 1'b0, 1'b1);
    wait_done(2, "ovf");
    checks++;
    if (result !== exp || overflow !== 1'b1 || term_count !== 8'd2) begin
      errors++;
      $display("FAIL ovf_result: res=%h ovf=%b cnt=%0d required %h 1 2", result, overflow, term_count, exp);
    end
  endtask

  task automatic test_subtract();
    start_expr();
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_cleared_on_start: ovf=%b required 0", overflow);
    end
    send_term(16'hFFFF, 1'b0, 1'b0);
    send_term(16'h8000, 1'b1, 1'b1);
    checks++;
    if (alu_h !== 1'b1 || alu_a !== 16'hFFFF || alu_b !== 16'h8000 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL sub_exec_ports: h=%b a=%h b=%h rdy=%b required 1 ffff 8000 0", alu_h, alu_a, alu_b, in_ready);
    end
    wait_done(2, "sub");
    checks++;
    if (result !== 16'h7FFF || overflow !== 1'b0) begin
      errors++; $display("FAIL sub_result: res=%h ovf=%b required 7fff 0", result, overflow);
    end
  endtask

  task automatic test_trunc();
    start_expr();
    send_term(16'd1, 1'b0, 1'b0);
    send_term(16'd1, 1'b0, 1'b0);
    send_term(16'd1, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL trunc_exec_ready: rdy=%b busy=%b required 0 1", in_ready, busy);
    end
    wait_done(2, "trunc");
    checks++;
    if (result !== 16'd3 || trunc_err !== 1'b1 || term_count !== 8'd3 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL trunc_result: res=%h tr=%b cnt=%0d rdy=%b required 0003 1 3 0",
               result, trunc_err, term_count, in_ready);
    end
    // Remaining terms offered while idle must be refused.
    in_valid = 1'b1; in_data = 16'd1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || term_count !== 8'd3 || result !== 16'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL trunc_idle_ignore: rdy=%b cnt=%0d res=%h busy=%b required 0 3 0003 0",
               in_ready, term_count, result, busy);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_hold();
    bit bad = 0;
    start_expr();
    send_term(16'd10, 1'b0, 1'b0);
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b1 || in_ready !== 1'b1 || result !== 16'd10 || done !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL hold_next: busy=%b rdy=%b res=%h required 1 1 000a", busy, in_ready, result);
    end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || term_count !== 8'd1 || result !== 16'd10) begin
      errors++;
      $display("FAIL start_while_busy: busy=%b rdy=%b cnt=%0d res=%h required 1 1 1 000a",
               busy, in_ready, term_count, result);
    end
    send_term(16'd4, 1'b1, 1'b1);
    wait_done(2, "hold");
    checks++;
    if (result !== 16'd6 || term_count !== 8'd2) begin
      errors++; $display("FAIL hold_result: res=%h cnt=%0d required 0006 2", result, term_count);
    end
  endtask

  task automatic test_reset_mid();
    start_expr();
    send_term(16'd1, 1'b0, 1'b0);
    send_term(16'd2, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, in_ready, done, overflow, trunc_err, alu_h} !== 6'b0 ||
        result !== '0 || term_count !== 8'd0 || alu_a !== '0 || alu_b !== '0) begin
      errors++;
      $display("FAIL reset_mid_exec: busy=%b rdy=%b done=%b ovf=%b tr=%b h=%b res=%h cnt=%0d a=%h b=%h required all 0",
               busy, in_ready, done, overflow, trunc_err, alu_h, result, term_count, alu_a, alu_b);
    end
    #1 rst = 1'b0;
    start_expr();
    send_term(16'd7, 1'b0, 1'b1);
    wait_done(1, "single");
    checks++;
    if (result !== 16'd7 || term_count !== 8'd1 || trunc_err !== 1'b0) begin
      errors++; $display("FAIL single_result: res=%h cnt=%0d tr=%b required 0007 1 0", result, term_count, trunc_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_subtract();
    test_trunc();
    test_hold();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/expr_alu_sequencer.md
Name: expr_alu_sequencer

Overview:
Sequencing controller that evaluates a chained signed expression (t0 ± t1 ± … ± tN-1) on the shared combinational add/sub ALU of the expression solver. Terms stream in over a valid/ready handshake, one ALU operation per term. The sequencer accumulates the result and a sticky overflow flag, then pulses done. It owns the ALU ports: it drives the select, operand A and operand B, and samples result and overflow.

Parameters:
WIDTH, 16, operand/result width (signed two's complement)
MAX_TERMS, 8, maximum terms per expression including t0 (2..255)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a new expression when idle
in_valid  input  1  term valid
in_ready  output  1  sequencer can accept a term
in_data  input  WIDTH  signed term value
in_op  input  1  0 = add term, 1 = subtract term (ignored for t0)
in_last  input  1  marks final term
alu_h  output  1  ALU select, registered (0 = add, 1 = subtract)
alu_a  output  WIDTH  ALU operand A = accumulator
alu_b  output  WIDTH  ALU operand B = latched term
alu_result  input  WIDTH  ALU result, combinational from alu_h/alu_a/alu_b
alu_overflow  input  1  ALU signed-overflow flag
busy  output  1  expression in progress
done  output  1  one-cycle pulse, result valid
result  output  WIDTH  final accumulator value, held until next start
overflow  output  1  sticky OR of ALU overflow across the expression
trunc_err  output  1  MAX_TERMS reached without in_last
term_count  output  8  terms accepted in current/last expression

Behaviour:
- Reset, applied at any time including mid-expression: state IDLE. All outputs and internal registers are 0: acc, b_reg, h_reg, term_count, overflow, trunc_err, done, busy, in_ready.
- States: IDLE, FIRST, NEXT, EXEC, DONE.
- IDLE: busy=0, in_ready=0.
  - start=1 → FIRST.
  - On this transition: clear overflow, trunc_err and term_count.
  - result keeps its previous value until the first acc write.
- FIRST: busy=1, in_ready=1.
  - On handshake (in_valid & in_ready): acc ← in_data and term_count ← 1; in_op is ignored.
  - If in_last → DONE, otherwise → NEXT.
- NEXT: busy=1, in_ready=1.
  - On handshake: b_reg ← in_data, h_reg ← in_op, last_reg ← in_last, term_count += 1 → EXEC.
  - With no handshake, remain in NEXT indefinitely.
- EXEC: busy=1, in_ready=0. Exactly one cycle.
  - ALU sees alu_a=acc, alu_b=b_reg, alu_h=h_reg.
  - At the clock edge: acc ← alu_result, overflow ← overflow | alu_overflow.
  - If last_reg → DONE.
  - Else if term_count == MAX_TERMS → DONE with trunc_err ← 1.
  - Else → NEXT.
- DONE: done=1 for exactly one cycle, busy=1, then → IDLE.
  - result mirrors acc; it is stable from done onward until the next start.
- alu_a, alu_b and alu_h are always driven from acc, b_reg and h_reg. They are only meaningful in EXEC.
- start is ignored outside IDLE. in_valid is ignored in IDLE, EXEC and DONE.
- Latency: last-term handshake in NEXT → EXEC next cycle → done the cycle after, i.e. 2 cycles. A single-term expression (t0 with in_last) gives done 1 cycle after the handshake.
- Arithmetic is WIDTH-bit wrap-around, as produced by the ALU. The sequencer performs no arithmetic beyond term_count.
- Overflow does not abort evaluation; later terms are still processed.

Optional Feature:
SATURATE_EN
- Defined: in EXEC, when alu_overflow=1, acc ← the WIDTH-bit signed max (0x7FFF at WIDTH 16) if acc[WIDTH-1]==0, otherwise the signed min (0x8000). The sticky overflow flag still sets.
- Undefined: acc ← alu_result, wrapped.

Test Plan:
- Reset, then start with terms 5(+), 3(+), 2(−, last) → done 2 cycles after the last handshake; result=6, overflow=0, term_count=3, trunc_err=0.
- Terms 0x7FFF(+), 1(+, last) → overflow=1. result=0x8000 without SATURATE_EN, 0x7FFF with it.
- Terms 0xFFFF(+), 0x8000(−, last), i.e. −1 − (−32768) → result=0x7FFF, overflow=0; confirms alu_h=1 during EXEC.
- MAX_TERMS=3, five terms of 1 with in_last never set → done after the 3rd term; result=3, trunc_err=1, in_ready=0 from EXEC onward.
- in_valid held low for 4 cycles in NEXT → state holds, busy=1, acc unchanged. A start pulse while busy → no effect.
- Assert rst during EXEC → all outputs 0 immediately. A subsequent start with a single term 7(last) → result=7, term_count=1.
